object_pose_ctrl: RTL
=====================

# object_pose_ctrl

Multi-object pose controller. It holds the centre position (Q1.10.10) and the rotation angles (Q1.2.13, radians) for NUM_OBJ scene objects. On each frame tick it updates the selected object from the 12-bit control pad, with saturation, angle wrap, hold-to-accelerate and a host load port. It feeds the vertex transform stage through a registered read port, replacing the single-object, free-running-per-clock pose register.

## Interface
- NUM_OBJ, 4, number of objects; must be at least 2. OBJ_W is $clog2(NUM_OBJ).
- POS_W, 21, position width (Q1.10.10).
- ANG_W, 16, angle width (Q1.2.13).
- POS_STEP, 21'h000400, base position step per tick (1.0).
- ANG_STEP, 16'h0020, base angle step per tick.
- POS_MIN / POS_MAX, -21'h0FFC00 / 21'h0FFC00, position saturation bounds.
- ACCEL_TICKS, 16, consecutive held ticks before the fast step applies.
- ACCEL_SHIFT, 2, fast step is the base step shifted left by this amount.
- fclk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- tick, input, 1, frame update strobe; one-cycle pulse.
- sel, input, OBJ_W, object that the pad controls.
- controlPad, input, 12, {FB, LR, UD, rotX, rotY, rotZ}; each field is 2 bits, 10 = plus, 01 = minus.
- load_valid / load_ready, input / output, 1 each, pose-load handshake.
- load_obj, input, OBJ_W, object to load.
- load_pos, input, 3*POS_W, {X, Y, Z}.
- load_ang, input, 3*ANG_W, {aX, aY, aZ}.
- rd_req, input, 1, read request.
- rd_obj, input, OBJ_W, object to read.
- rd_valid, output, 1, read data valid.
- Xc, Yc, Zc, output, POS_W each, read position.
- angleX, angleY, angleZ, output, ANG_W each, read angles.

## Operation
- Pose storage:
  - Each object has a register file of X, Y, Z, aX, aY, aZ.
  - Reset value for every object: X = Y = 0, Z = 21'h00B400, all angles = 0.
- Pad decoding on tick:
  - FB: 10 gives Z+, 01 gives Z-.
  - LR: 10 gives X-, 01 gives X+.
  - UD: 10 gives Y-, 01 gives Y+.
  - rot fields: 10 gives angle+, 01 gives angle-.
  - Field values 00 and 11 leave that axis unchanged.
  - Only object sel is modified.
- Position arithmetic:
  - Computed in POS_W+1 bits.
  - Result is clamped to [POS_MIN, POS_MAX] and never wraps.
- Angle arithmetic:
  - Computed in ANG_W+1 bits.
  - If the result is greater than PI (16'h6488), subtract TWO_PI (17'h0C910).
  - If the result is less than -PI, add TWO_PI.
  - The stored angle therefore always lies in [-PI, PI].
- Acceleration:
  - Each of the 6 axes has a hold counter.
  - The counter increments on each tick where the field is non-neutral and has the same sign as on the previous tick. It saturates at ACCEL_TICKS.
  - The counter clears on a neutral field, a sign reversal, a change of sel, or reset.
  - While the counter is below ACCEL_TICKS the base step applies; at ACCEL_TICKS the fast step applies.
- Load port:
  - A transfer occurs when load_valid and load_ready are both 1 at the clock edge.
  - load_ready is held at 1 except in the cycle immediately after an accepted load. That stall cycle is the single-cycle write bubble.
  - A load writes all six fields verbatim, without clamp or wrap.
  - A load does not clear the hold counters.
- Read port:
  - rd_req latches rd_obj.
  - On the next cycle, Xc through angleZ hold that object's pose and rd_valid = 1 for exactly one cycle.
  - The outputs keep their last value while rd_valid = 0.
- Simultaneous events:
  - Load and tick targeting the same object in the same cycle: the load wins and that tick is dropped for that object. Hold counters still update.
  - Load and tick targeting different objects: both are applied.
  - Read of an object written in the same cycle: returns the pre-write value.
- Reset:
  - All poses, hold counters and read outputs go to their reset values; rd_valid = 0 and load_ready = 1.
  - A handshake in flight when reset asserts is discarded.

## Timing
- Updates from tick and from load both commit at the clock edge where they are sampled.
- Read latency is 1 cycle: rd_req sampled at edge N gives rd_valid high after edge N+1.
- Load throughput is one transfer every 2 cycles.
- No combinational path exists from any input to any output.

## Structure
- Package obj_pose_pkg contains:
  - the reset-pose constants;
  - PI and TWO_PI;
  - the pad field bit positions and the encodings 10 and 01;
  - the tetrahedron vertex constants, B = 10, shared with the transform stage.
- Sub-module pose_axis_step:
  - One instance per axis, 6 instances in total.
  - Inputs: current value, pad field, sel-changed flag and tick. Outputs: next value and the hold counter.
  - Parameter MODE selects clamp (position axes) or wrap (angle axes).

## Test plan
- Reset, then rd_obj = 2 → Zc = 21'h00B400, all other outputs 0, rd_valid is a 1-cycle pulse.
- sel = 1, FB = 10 for 3 ticks → object 1 Z = 21'h00C000; objects 0, 2 and 3 are unchanged.
- rotX = 10 held for 20 ticks (ACCEL_TICKS = 16) → aX = 16·0x20 + 4·0x80 = 16'h0400. Releasing the field, then pressing again → the step returns to 0x20.
- Load aZ = 16'h6480, then rotZ = 10 with one tick → aZ = 16'h6480 + 0x20 − 0xC910 = 16'h9B90 (−PI + 0x18).
- Load X = POS_MAX − 21'h000200, then LR = 01 with one tick → X = POS_MAX exactly.
- Load to object 0 and tick with sel = 0, FB = 10, in the same cycle → the loaded value is stored, load_ready is low for the next cycle, and a same-cycle read returns the old pose.

Source files
------------

// File: rtl/object_pose_ctrl_pkg.sv
// rtl/object_pose_ctrl_pkg.sv - shared constants for the object pose controller and transform stage
// Contents: default widths, reset pose, PI / TWO_PI, control pad field layout and
// encodings, axis step modes, tetrahedron vertex constants (B = 10).
package obj_pose_pkg;

    localparam int DEF_NUM_OBJ = 4;
    localparam int DEF_OBJ_W   = $clog2(DEF_NUM_OBJ);
    localparam int DEF_POS_W   = 21;
    localparam int DEF_ANG_W   = 16;

    // Reset pose: object sits 45.0 units in front of the camera, unrotated.
    localparam logic [DEF_POS_W-1:0] RST_POS_X = 21'h000000;
    localparam logic [DEF_POS_W-1:0] RST_POS_Y = 21'h000000;
    localparam logic [DEF_POS_W-1:0] RST_POS_Z = 21'h00B400;
    localparam logic [DEF_ANG_W-1:0] RST_ANG   = 16'h0000;

    // Q1.2.13 radians.
    localparam logic [DEF_ANG_W-1:0] ANG_PI     = 16'h6488;
    localparam logic [DEF_ANG_W:0]   ANG_TWO_PI = 17'h0C910;

    // controlPad = {FB, LR, UD, rotX, rotY, rotZ}, 2 bits each.
    localparam int PAD_FB_LSB = 10;
    localparam int PAD_LR_LSB = 8;
    localparam int PAD_UD_LSB = 6;
    localparam int PAD_RX_LSB = 4;
    localparam int PAD_RY_LSB = 2;
    localparam int PAD_RZ_LSB = 0;

    localparam logic [1:0] PAD_PLUS  = 2'b10;
    localparam logic [1:0] PAD_MINUS = 2'b01;

    localparam int MODE_CLAMP = 0;
    localparam int MODE_WRAP  = 1;

    // Tetrahedron model vertices {x, y, z}, signed 8-bit, shared with the transform stage.
    localparam int TETRA_B = 10;
    localparam logic [23:0] TETRA_V0 = {8'sd10,  8'sd10,  8'sd10};
    localparam logic [23:0] TETRA_V1 = {8'sd10, -8'sd10, -8'sd10};
    localparam logic [23:0] TETRA_V2 = {-8'sd10, 8'sd10, -8'sd10};
    localparam logic [23:0] TETRA_V3 = {-8'sd10, -8'sd10, 8'sd10};

    function automatic logic [1:0] pad_field(input logic [11:0] pad, input int lsb);
        return pad[lsb +: 2];
    endfunction

endpackage

// File: rtl/object_pose_ctrl_if.sv
// rtl/object_pose_ctrl_if.sv - host load port and pose read port bundle
// Signals: load_valid/load_ready/load_obj/load_pos{X,Y,Z}/load_ang{aX,aY,aZ};
// rd_req/rd_obj in, rd_valid/Xc/Yc/Zc/angleX/angleY/angleZ out.
// master = host / transform stage side, slave = pose controller side.
interface object_pose_ctrl_if
    import obj_pose_pkg::*;
#(
    parameter int OBJ_W = DEF_OBJ_W,
    parameter int POS_W = DEF_POS_W,
    parameter int ANG_W = DEF_ANG_W
);
    logic               load_valid;
    logic               load_ready;
    logic [OBJ_W-1:0]   load_obj;
    logic [3*POS_W-1:0] load_pos;
    logic [3*ANG_W-1:0] load_ang;

    logic               rd_req;
    logic [OBJ_W-1:0]   rd_obj;
    logic               rd_valid;
    logic [POS_W-1:0]   Xc, Yc, Zc;
    logic [ANG_W-1:0]   angleX, angleY, angleZ;

    modport master (
        output load_valid, load_obj, load_pos, load_ang, rd_req, rd_obj,
        input  load_ready, rd_valid, Xc, Yc, Zc, angleX, angleY, angleZ
    );

    modport slave (
        input  load_valid, load_obj, load_pos, load_ang, rd_req, rd_obj,
        output load_ready, rd_valid, Xc, Yc, Zc, angleX, angleY, angleZ
    );
endinterface

// File: rtl/object_pose_ctrl_pose_axis_step.sv
// rtl/object_pose_ctrl_pose_axis_step.sv - next-value and hold-count logic for one pose axis
// Inputs: cur_i (selected object's value), field_i (pad field), prev_i / cnt_i
// (field and hold count from the previous tick), sel_chg_i, tick_i.
// Outputs: nxt_o (value to store on tick), hold_cnt_o (hold count to store).
// MODE_CLAMP saturates to [MIN_V, MAX_V]; MODE_WRAP folds by SPAN into [MIN_V, MAX_V].
module pose_axis_step
    import obj_pose_pkg::*;
#(
    parameter int           W           = DEF_POS_W,
    parameter int           MODE        = MODE_CLAMP,
    parameter bit           NEG         = 1'b0,
    parameter logic [W-1:0] STEP        = '0,
    parameter logic [W-1:0] MIN_V       = '0,
    parameter logic [W-1:0] MAX_V       = '0,
    parameter logic [W:0]   SPAN        = '0,
    parameter int           ACCEL_TICKS = 16,
    parameter int           ACCEL_SHIFT = 2,
    parameter int           CNT_W       = 5
) (
    input  logic [W-1:0]     cur_i,
    input  logic [1:0]       field_i,
    input  logic [1:0]       prev_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             sel_chg_i,
    input  logic             tick_i,
    output logic [W-1:0]     nxt_o,
    output logic [CNT_W-1:0] hold_cnt_o
);
    localparam logic signed [W:0]   BASE_X  = $signed({1'b0, STEP});
    localparam logic signed [W:0]   FAST_X  = BASE_X <<< ACCEL_SHIFT;
    localparam logic signed [W:0]   MIN_X   = $signed({MIN_V[W-1], MIN_V});
    localparam logic signed [W:0]   MAX_X   = $signed({MAX_V[W-1], MAX_V});
    localparam logic signed [W:0]   SPAN_X  = $signed(SPAN);
    localparam logic [CNT_W-1:0]    ACCEL_C = CNT_W'(ACCEL_TICKS);

    logic             is_plus, is_minus, same_dir, go_up, go_dn;
    logic [CNT_W-1:0] cnt_d;
    logic signed [W:0] cur_x, step_x, sum_x, res_x;

    assign is_plus  = (field_i == PAD_PLUS);
    assign is_minus = (field_i == PAD_MINUS);
    assign same_dir = (is_plus || is_minus) && (field_i == prev_i);
    // LR and UD move the object opposite to the pad's "plus" encoding.
    assign go_up    = NEG ? is_minus : is_plus;
    assign go_dn    = NEG ? is_plus  : is_minus;
    assign cur_x    = $signed({cur_i[W-1], cur_i});

    always_comb begin
        cnt_d  = cnt_i;
        step_x = BASE_X;
        sum_x  = cur_x;
        res_x  = cur_x;
        if (tick_i) begin
            if (sel_chg_i || !same_dir) begin
                cnt_d = '0;
            end else if (cnt_i < ACCEL_C) begin
                cnt_d = cnt_i + 1'b1;
            end
        end
        // The step uses this tick's count, so the 17th held tick is the first fast one.
        if (cnt_d == ACCEL_C) begin
            step_x = FAST_X;
        end
        if (go_up) begin
            sum_x = cur_x + step_x;
        end else if (go_dn) begin
            sum_x = cur_x - step_x;
        end
        // Only a moving axis is clamped/wrapped; a verbatim-loaded value is left alone otherwise.
        if (go_up || go_dn) begin
            if (MODE == MODE_CLAMP) begin
                if (sum_x > MAX_X) begin
                    res_x = MAX_X;
                end else if (sum_x < MIN_X) begin
                    res_x = MIN_X;
                end else begin
                    res_x = sum_x;
                end
            end else begin
                if (sum_x > MAX_X) begin
                    res_x = sum_x - SPAN_X;
                end else if (sum_x < MIN_X) begin
                    res_x = sum_x + SPAN_X;
                end else begin
                    res_x = sum_x;
                end
            end
        end
    end

    assign nxt_o      = tick_i ? res_x[W-1:0] : cur_i;
    assign hold_cnt_o = cnt_d;
endmodule

// File: rtl/object_pose_ctrl.sv
// rtl/object_pose_ctrl.sv - multi-object pose register file with pad stepping, load and read ports
// Ports: fclk, rst (async, active-high), tick (frame strobe), sel (pad target object),
// controlPad {FB,LR,UD,rotX,rotY,rotZ}, bus (object_pose_ctrl_if.slave: load handshake
// with one bubble cycle after each transfer, 1-cycle-latency registered pose read).
module object_pose_ctrl
    import obj_pose_pkg::*;
#(
    parameter int                 NUM_OBJ     = DEF_NUM_OBJ,
    parameter int                 POS_W       = DEF_POS_W,
    parameter int                 ANG_W       = DEF_ANG_W,
    parameter logic [POS_W-1:0]   POS_STEP    = 21'h000400,
    parameter logic [ANG_W-1:0]   ANG_STEP    = 16'h0020,
    parameter logic [POS_W-1:0]   POS_MIN     = -21'h0FFC00,
    parameter logic [POS_W-1:0]   POS_MAX     = 21'h0FFC00,
    parameter int                 ACCEL_TICKS = 16,
    parameter int                 ACCEL_SHIFT = 2
) (
    input  logic                      fclk,
    input  logic                      rst,
    input  logic                      tick,
    input  logic [$clog2(NUM_OBJ)-1:0] sel,
    input  logic [11:0]               controlPad,
    object_pose_ctrl_if.slave         bus
);
    localparam int                 OBJ_W   = $clog2(NUM_OBJ);
    localparam int                 CNT_W   = $clog2(ACCEL_TICKS + 1);
    localparam logic [ANG_W-1:0]   ANG_MIN = -ANG_PI;

    logic [POS_W-1:0] pos_q [NUM_OBJ][3];
    logic [ANG_W-1:0] ang_q [NUM_OBJ][3];

    // Hold state is per axis (6 total), shared by whichever object sel points at.
    logic [1:0]       prev_q [6];
    logic [CNT_W-1:0] cnt_q  [6];
    logic [CNT_W-1:0] cnt_d  [6];
    logic [1:0]       fld    [6];
    logic [OBJ_W-1:0] sel_q;
    logic             sel_chg;

    logic [POS_W-1:0] pos_cur [3];
    logic [POS_W-1:0] pos_nxt [3];
    logic [ANG_W-1:0] ang_cur [3];
    logic [ANG_W-1:0] ang_nxt [3];

    logic             load_ready_q;
    logic             load_acc;

    logic             rd_pend_q;
    logic             rd_valid_q;
    logic [POS_W-1:0] snap_pos_q [3];
    logic [ANG_W-1:0] snap_ang_q [3];
    logic [POS_W-1:0] out_pos_q  [3];
    logic [ANG_W-1:0] out_ang_q  [3];

    // Axis order 0..2 = X, Y, Z; 3..5 = aX, aY, aZ.
    assign fld[0] = pad_field(controlPad, PAD_LR_LSB);
    assign fld[1] = pad_field(controlPad, PAD_UD_LSB);
    assign fld[2] = pad_field(controlPad, PAD_FB_LSB);
    assign fld[3] = pad_field(controlPad, PAD_RX_LSB);
    assign fld[4] = pad_field(controlPad, PAD_RY_LSB);
    assign fld[5] = pad_field(controlPad, PAD_RZ_LSB);

    assign sel_chg  = (sel != sel_q);
    assign load_acc = bus.load_valid && load_ready_q;

    for (genvar p = 0; p < 3; p++) begin : g_axis
        assign pos_cur[p] = pos_q[sel][p];
        assign ang_cur[p] = ang_q[sel][p];

        pose_axis_step #(
            .W(POS_W), .MODE(MODE_CLAMP), .NEG(p != 2), .STEP(POS_STEP),
            .MIN_V(POS_MIN), .MAX_V(POS_MAX), .SPAN('0),
            .ACCEL_TICKS(ACCEL_TICKS), .ACCEL_SHIFT(ACCEL_SHIFT), .CNT_W(CNT_W)
        ) u_pos (
            .cur_i(pos_cur[p]), .field_i(fld[p]), .prev_i(prev_q[p]), .cnt_i(cnt_q[p]),
            .sel_chg_i(sel_chg), .tick_i(tick), .nxt_o(pos_nxt[p]), .hold_cnt_o(cnt_d[p])
        );

        pose_axis_step #(
            .W(ANG_W), .MODE(MODE_WRAP), .NEG(1'b0), .STEP(ANG_STEP),
            .MIN_V(ANG_MIN), .MAX_V(ANG_PI), .SPAN(ANG_TWO_PI),
            .ACCEL_TICKS(ACCEL_TICKS), .ACCEL_SHIFT(ACCEL_SHIFT), .CNT_W(CNT_W)
        ) u_ang (
            .cur_i(ang_cur[p]), .field_i(fld[p+3]), .prev_i(prev_q[p+3]), .cnt_i(cnt_q[p+3]),
            .sel_chg_i(sel_chg), .tick_i(tick), .nxt_o(ang_nxt[p]), .hold_cnt_o(cnt_d[p+3])
        );
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_OBJ; o++) begin
                pos_q[o][0] <= RST_POS_X;
                pos_q[o][1] <= RST_POS_Y;
                pos_q[o][2] <= RST_POS_Z;
                for (int p = 0; p < 3; p++) begin
                    ang_q[o][p] <= RST_ANG;
                end
            end
            for (int a = 0; a < 6; a++) begin
                prev_q[a] <= 2'b00;
                cnt_q[a]  <= '0;
            end
            sel_q        <= '0;
            load_ready_q <= 1'b1;
            rd_pend_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            for (int p = 0; p < 3; p++) begin
                snap_pos_q[p] <= '0;
                snap_ang_q[p] <= '0;
                out_pos_q[p]  <= '0;
                out_ang_q[p]  <= '0;
            end
        end else begin
            // A transfer forces exactly one stall cycle (the write bubble).
            load_ready_q <= !load_acc;

            if (tick) begin
                sel_q <= sel;
                for (int a = 0; a < 6; a++) begin
                    prev_q[a] <= fld[a];
                    cnt_q[a]  <= cnt_d[a];
                end
            end

            // Load has priority over a tick aimed at the same object.
            for (int o = 0; o < NUM_OBJ; o++) begin
                if (load_acc && (bus.load_obj == OBJ_W'(o))) begin
                    for (int p = 0; p < 3; p++) begin
                        pos_q[o][p] <= bus.load_pos[(3-p)*POS_W-1 -: POS_W];
                        ang_q[o][p] <= bus.load_ang[(3-p)*ANG_W-1 -: ANG_W];
                    end
                end else if (tick && (sel == OBJ_W'(o))) begin
                    for (int p = 0; p < 3; p++) begin
                        pos_q[o][p] <= pos_nxt[p];
                        ang_q[o][p] <= ang_nxt[p];
                    end
                end
            end

            // Snapshot at the request edge gives pre-write data; present it one edge later.
            rd_pend_q  <= bus.rd_req;
            rd_valid_q <= rd_pend_q;
            if (bus.rd_req) begin
                for (int p = 0; p < 3; p++) begin
                    snap_pos_q[p] <= pos_q[bus.rd_obj][p];
                    snap_ang_q[p] <= ang_q[bus.rd_obj][p];
                end
            end
            if (rd_pend_q) begin
                for (int p = 0; p < 3; p++) begin
                    out_pos_q[p] <= snap_pos_q[p];
                    out_ang_q[p] <= snap_ang_q[p];
                end
            end
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.Xc         = out_pos_q[0];
    assign bus.Yc         = out_pos_q[1];
    assign bus.Zc         = out_pos_q[2];
    assign bus.angleX     = out_ang_q[0];
    assign bus.angleY     = out_ang_q[1];
    assign bus.angleZ     = out_ang_q[2];
endmodule
